fwd_scoreboard_pipe: RTL

//  Parametrised in-flight register-write tracker that replaces fixed 3-stage forwarding and stall logic.

---
 rtl/fwd_scoreboard_pipe_if.sv | 34 +++
 rtl/fwd_scoreboard_pipe.sv | 113 +++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_pipe_if.sv
// Execute/decode/writeback bundle for the in-flight write tracker.
// master drives the execute and decode side; slave is the tracker itself.
interface fwd_scoreboard_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2
);
  logic                       freeze;
  logic                       flush;
  logic                       ex_valid;
  logic                       ex_we;
  logic                       ex_is_load;
  logic [4:0]                 ex_rd;
  logic [XLEN-1:0]            ex_data;
  logic [XLEN-1:0]            ld_data;
  logic [NREAD-1:0][4:0]      rd_adr;
  logic [NREAD-1:0][XLEN-1:0] rf_data;
  logic [NREAD-1:0][XLEN-1:0] fwd_data;
  logic [NREAD-1:0]           fwd_hit;
  logic                       stall;
  logic                       wb_valid;
  logic [4:0]                 wb_rd;
  logic [XLEN-1:0]            wb_data;

  modport master (
    output freeze, flush, ex_valid, ex_we, ex_is_load, ex_rd, ex_data, ld_data,
           rd_adr, rf_data,
    input  fwd_data, fwd_hit, stall, wb_valid, wb_rd, wb_data
  );
  modport slave (
    input  freeze, flush, ex_valid, ex_we, ex_is_load, ex_rd, ex_data, ld_data,
           rd_adr, rf_data,
    output fwd_data, fwd_hit, stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/fwd_scoreboard_pipe.sv
// In-flight register-write tracker: DEPTH-entry shift pipeline of pending writes,
// per-port operand forwarding / load-use stall, and register-file writeback from the oldest entry.

// One decode read port: youngest matching valid entry wins.
module fwd_lookup_port #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3
) (
  input  logic [4:0]                 adr_i,
  input  logic [XLEN-1:0]            rf_i,
  input  logic [DEPTH-1:0]           vld_i,
  input  logic [DEPTH-1:0]           rdy_i,
  input  logic [DEPTH-1:0][4:0]      rd_i,
  input  logic [DEPTH-1:0][XLEN-1:0] dat_i,
  output logic [XLEN-1:0]            data_o,
  output logic                       hit_o,
  output logic                       stall_o
);
  logic            found;
  logic            win_rdy;
  logic [XLEN-1:0] win_dat;

  always_comb begin
    found   = 1'b0;
    win_rdy = 1'b0;
    win_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && vld_i[k] && rd_i[k] == adr_i) begin
        found   = 1'b1;
        win_rdy = rdy_i[k];
        win_dat = dat_i[k];
      end
    end
    // x0 never matches because ex_rd==0 is never tracked; the explicit guard keeps it obvious.
    hit_o   = (adr_i != 5'd0) && found && win_rdy;
    stall_o = (adr_i != 5'd0) && found && !win_rdy;
    data_o  = hit_o ? win_dat : rf_i;
  end
endmodule

module fwd_scoreboard_pipe #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int NREAD      = 2
) (
  input logic                 clk,
  input logic                 reset,
  fwd_scoreboard_pipe_if.slave bus
);
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0]           rdy_q, rdy_d;
  logic [DEPTH-1:0][4:0]      rd_q,  rd_d;
  logic [DEPTH-1:0][XLEN-1:0] dat_q, dat_d;
  logic [NREAD-1:0]           port_stall;

  always_comb begin
    vld_d = vld_q;
    rdy_d = rdy_q;
    rd_d  = rd_q;
    dat_d = dat_q;
    if (!bus.freeze) begin
      vld_d[0] = bus.ex_valid & bus.ex_we & (bus.ex_rd != 5'd0) & ~bus.flush;
      rdy_d[0] = ~bus.ex_is_load;
      rd_d[0]  = bus.ex_rd;
      dat_d[0] = bus.ex_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        rdy_d[k] = rdy_q[k-1];
        rd_d[k]  = rd_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
      // Load data lands on the entry as it shifts into LOAD_STAGE.
      if (vld_q[LOAD_STAGE-1] && !rdy_q[LOAD_STAGE-1]) begin
        rdy_d[LOAD_STAGE] = 1'b1;
        dat_d[LOAD_STAGE] = bus.ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      rdy_q <= '0;
      rd_q  <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
      rd_q  <= rd_d;
      dat_q <= dat_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_lookup_port #(.XLEN(XLEN), .DEPTH(DEPTH)) u_port (
      .adr_i   (bus.rd_adr[p]),
      .rf_i    (bus.rf_data[p]),
      .vld_i   (vld_q),
      .rdy_i   (rdy_q),
      .rd_i    (rd_q),
      .dat_i   (dat_q),
      .data_o  (bus.fwd_data[p]),
      .hit_o   (bus.fwd_hit[p]),
      .stall_o (port_stall[p])
    );
  end

  assign bus.stall    = |port_stall;
  assign bus.wb_valid = vld_q[DEPTH-1];
  assign bus.wb_rd    = rd_q[DEPTH-1];
  assign bus.wb_data  = dat_q[DEPTH-1];
endmodule
